// File: rtl/serial_tx.sv
// UART-style parallel-to-serial transmitter: start bit, LSB-first data, one stop bit.
// out is registered; in_ready is low for the whole frame, so in_valid is ignored while busy.
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [BW-1:0]          bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt, shifted;
  logic                   out_nxt, ready_nxt, busy_nxt;
  logic                   bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign shifted = shreg >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      out      <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      out      <= out_nxt;
      in_ready <= ready_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    out_nxt     = out;
    ready_nxt   = in_ready;
    busy_nxt    = busy;

    // The counter free-runs through every bit period of a frame and wraps at CNT_LAST.
    if (state != IDLE) begin
      cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        out_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          shreg_nxt = in;
          state_nxt = START;
          out_nxt   = 1'b0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          out_nxt     = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
            state_nxt = STOP;
            out_nxt   = 1'b1;
          end else begin
            shreg_nxt   = shifted;
            out_nxt     = shifted[0];
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        out_nxt = 1'b1;
        if (bit_end) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: stimulus queues hand-computed line patterns, per-DUT monitors
// detect accepts and compare each bit slot, busy length and return to idle.
module tb_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in0 = 8'h00, in1 = 8'h00;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic       rdy0, rdy1, out0, out1, busy0, busy1;

  serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .in(in0), .in_valid(vld0),
    .in_ready(rdy0), .out(out0), .busy(busy0));

  serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(vld1),
    .in_ready(rdy1), .out(out1), .busy(busy1));

  logic out_s[2], busy_s[2], rdy_s[2], vld_s[2];
  assign out_s[0] = out0;   assign out_s[1] = out1;
  assign busy_s[0] = busy0; assign busy_s[1] = busy1;
  assign rdy_s[0] = rdy0;   assign rdy_s[1] = rdy1;
  assign vld_s[0] = vld0;   assign vld_s[1] = vld1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hi_run = 0, last_hi = 0;
  int acc_cnt0 = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Line-high run length and accept count for the C=4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (out0) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
    end
    if (rst && vld0 && rdy0) acc_cnt0 = acc_cnt0 + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Slot j of a frame pattern is bit j: start, data LSB first, stop.
  task automatic monitor(input int u, input int c);
    logic [9:0] e;
    bit have = 0;
    bit aborted;
    bit valid_e;
    int bc;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (rst && vld_s[u] && rdy_s[u]) begin
        valid_e = 1;
        e = '0;
        if (u == 0) begin
          if (q0.size() == 0) valid_e = 0; else e = q0.pop_front();
        end else begin
          if (q1.size() == 0) valid_e = 0; else e = q1.pop_front();
        end
        if (!valid_e) chk($sformatf("u%0d unexpected accept", u), 1, 0);
        aborted = 0;
        bc = 0;
        for (int j = 0; j < 10 && !aborted; j++) begin
          for (int t = 0; t < c && !aborted; t++) begin
            @(negedge clk);
            if (!rst) aborted = 1;
            else begin
              if (busy_s[u]) bc++;
              if (t == 0 && valid_e)
                chk($sformatf("u%0d slot%0d", u, j), int'(out_s[u]), int'(e[j]));
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          chk($sformatf("u%0d busy clocks", u), bc, 10 * c);
          chk($sformatf("u%0d busy after frame", u), int'(busy_s[u]), 0);
          chk($sformatf("u%0d ready after frame", u), int'(rdy_s[u]), 1);
          have = 1;
        end
      end
    end
  endtask

  initial monitor(0, 4);
  initial monitor(1, 1);

  // Must be called #1 after a rising edge; returns the cycle number of the accepting edge.
  task automatic send(input int u, input logic [7:0] w, input logic [9:0] e,
                      input bit hold, output int k);
    int n = 0;
    if (u == 0) begin q0.push_back(e); in0 = w; vld0 = 1'b1; end
    else        begin q1.push_back(e); in1 = w; vld1 = 1'b1; end
    while (!rdy_s[u] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk($sformatf("u%0d accept timeout", u), n, 0);
    @(posedge clk); #1;
    k = cyc;
    if (!hold) begin
      if (u == 0) vld0 = 1'b0; else vld1 = 1'b0;
    end
  endtask

  initial begin
    int k1, k2, a0;
    @(negedge clk);
    chk("reset out", int'(out0), 1);
    chk("reset busy", int'(busy0), 0);
    chk("reset ready", int'(rdy0), 0);
    chk("reset out c1", int'(out1), 1);
    chk("reset ready c1", int'(rdy1), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("ready before first edge", int'(rdy0), 0);
    @(posedge clk); #1;
    chk("ready first edge", int'(rdy0), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("idle out", int'(out0), 1);
    chk("idle busy", int'(busy0), 0);
    chk("idle ready", int'(rdy0), 1);

    // single frame A5
    send(0, 8'hA5, 10'b1101001010, 1'b0, k1);
    repeat (45) @(posedge clk);
    #1;

    // back-to-back 00 then FF with in_valid held
    send(0, 8'h00, 10'b1000000000, 1'b1, k1);
    send(0, 8'hFF, 10'b1111111110, 1'b0, k2);
    chk("b2b accept spacing", k2 - k1, 41);
    @(posedge clk); #1;
    chk("b2b line high gap", last_hi, 5);
    repeat (45) @(posedge clk);
    #1;

    // input stability: 3C with in/in_valid toggling during the frame
    a0 = acc_cnt0;
    send(0, 8'h3C, 10'b1001111000, 1'b0, k1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy0) break;
      in0 = ~in0;
      vld0 = ~vld0;
    end
    vld0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("single accept while busy", acc_cnt0 - a0, 1);

    // reset during data bit 3 of 0F, then a clean 81 frame
    send(0, 8'h0F, 10'b1000011110, 1'b0, k1);
    repeat (17) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midframe reset out", int'(out0), 1);
    chk("midframe reset busy", int'(busy0), 0);
    chk("midframe reset ready", int'(rdy0), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    send(0, 8'h81, 10'b1100000010, 1'b0, k1);
    repeat (45) @(posedge clk);
    #1;

    // minimum divider
    send(1, 8'h5A, 10'b1010110100, 1'b0, k1);
    repeat (15) @(posedge clk);
    #1;

    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
